nfc_cmd_queue: RTL



---
 rtl/nfc_pkg.sv | 21 ++
 rtl/nfc_cmd_fifo.sv | 60 ++++++
 rtl/nfc_cmd_queue.sv | 120 ++++++++++++
 3 files changed

// File: rtl/nfc_pkg.sv
// nfc_pkg: shared definitions for the NAND flash controller command path.
// Holds the 33-bit command field layout and the issue-side state encoding.
// Used by the command queue, the NFC and the testbench.
package nfc_pkg;

  localparam int CMD_W   = 33;
  localparam int RW_BIT  = 32;
  localparam int AF_MSB  = 31;
  localparam int AF_LSB  = 14;
  localparam int AM_MSB  = 13;
  localparam int AM_LSB  = 7;
  localparam int LEN_MSB = 6;
  localparam int LEN_LSB = 0;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    FREE = 2'd1,
    BUSY = 2'd2
  } nfc_state_e;

endpackage

// File: rtl/nfc_cmd_fifo.sv
// nfc_cmd_fifo: synchronous FIFO for NFC commands.
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointers/count only)
//   push, wdata   write request and data (ignored when full)
//   pop           read request (ignored when empty)
//   head          entry at the read pointer
//   full, empty   occupancy flags
//   count         occupancy, log2(DEPTH)+1 bits
module nfc_cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 33
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [W-1:0]             wdata,
  input  logic                     pop,
  output logic [W-1:0]             head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == FULL_CNT);
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = mem[rd_ptr];

  // Storage is deliberately not reset; only the bookkeeping is.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/nfc_cmd_queue.sv
// nfc_cmd_queue: buffers host transfer commands and issues them to the NFC
// one at a time, pacing on the NFC done pulse.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   h_cmd, h_valid      host command and valid; h_ready = !full
//   cmd, cmd_vld        registered command to NFC and its one-cycle strobe
//   done                NFC free pulse (once after reset, then per command)
//   idle                FIFO empty and NFC free
//   done_cnt            completed commands (wraps)
//   drop_cnt            dropped zero-length commands (saturates at 255)
module nfc_cmd_queue
  import nfc_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [32:0]      h_cmd,
  input  logic             h_valid,
  output logic             h_ready,
  output logic [32:0]      cmd,
  output logic             cmd_vld,
  input  logic             done,
  output logic             idle,
  output logic [CNTW-1:0]  done_cnt,
  output logic [7:0]       drop_cnt
);

  localparam int AW = $clog2(DEPTH);

  nfc_state_e        state;
  nfc_state_e        next_state;
  logic              pop;
  logic              cnt_inc;
  logic              push_fire;
  logic              len_zero;
  logic              fifo_push;
  logic [CMD_W-1:0]  head;
  logic              full;
  logic              empty;
  logic [AW:0]       count;

  assign h_ready   = ~full;
  assign push_fire = h_valid & h_ready;
  assign len_zero  = (h_cmd[LEN_MSB:LEN_LSB] == '0);
  assign fifo_push = push_fire & ~len_zero;
  assign idle      = (count == '0) && (state == FREE);

  nfc_cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .wdata (h_cmd),
    .pop   (pop),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    next_state = state;
    pop        = 1'b0;
    cnt_inc    = 1'b0;
    case (state)
      INIT: begin
        if (done) next_state = FREE;
      end
      FREE: begin
        // done here is spurious and ignored.
        if (!empty) begin
          pop        = 1'b1;
          next_state = BUSY;
        end
      end
      BUSY: begin
        if (done) begin
          cnt_inc = 1'b1;
          // A done coincident with the issue strobe is completed but the
          // next issue is deferred a cycle through FREE, so cmd_vld never
          // stays high on consecutive cycles.
          if (!empty && !cmd_vld) pop = 1'b1;
          else                    next_state = FREE;
        end
      end
      default: next_state = INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= INIT;
    else     state <= next_state;
  end

  // Issue register: the popped head is presented the cycle after the pop.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd     <= '0;
      cmd_vld <= 1'b0;
    end else begin
      cmd_vld <= pop;
      if (pop) cmd <= head;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done_cnt <= '0;
      drop_cnt <= '0;
    end else begin
      if (cnt_inc) done_cnt <= done_cnt + CNTW'(1);
      if (push_fire && len_zero && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

endmodule
